// File: rtl/mem_pkg.sv
// Shared types and constants for the data-segment memory access unit.
package mem_pkg;

   // Default data-segment depth in 32-bit words
   localparam int SEG_WORDS_DEFAULT = 32;

   // Access size encoding as carried on req_size
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane helper: extracts and extends a load lane from a memory word,
// and merges a right-aligned store lane into an existing word.
module mem_lane_unit
   import mem_pkg::*;
(
   input  logic [31:0] rd_word_i,    // word read from memory (load path)
   input  logic [31:0] old_word_i,   // previously read word (store path)
   input  logic [31:0] new_data_i,   // right-aligned store data
   input  logic [1:0]  lane_i,       // addr[1:0]
   input  size_e       size_i,
   input  logic        signed_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Byte lane = addr[1:0], half lane = addr[1]; little-endian lane 0 = bits 7:0
   assign byte_sh  = {lane_i, 3'b000};
   assign half_sh  = {lane_i[1], 4'b0000};
   assign sel_byte = 8'(rd_word_i >> byte_sh);
   assign sel_half = 16'(rd_word_i >> half_sh);

   // Extract the addressed lane and sign/zero extend it to 32 bits
   always_comb begin
      load_data_o = rd_word_i;
      case (size_i)
         SZ_BYTE: load_data_o = {{24{signed_i & sel_byte[7]}}, sel_byte};
         SZ_HALF: load_data_o = {{16{signed_i & sel_half[15]}}, sel_half};
         default: load_data_o = rd_word_i;
      endcase
   end

   // Replace only the addressed lane; every other byte of the old word survives
   always_comb begin
      merged_o = new_data_i;
      case (size_i)
         SZ_BYTE: merged_o = (old_word_i & ~(32'h0000_00FF << byte_sh))
                           | ({24'h0, new_data_i[7:0]} << byte_sh);
         SZ_HALF: merged_o = (old_word_i & ~(32'h0000_FFFF << half_sh))
                           | ({16'h0, new_data_i[15:0]} << half_sh);
         default: merged_o = new_data_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data segment of the unified memory.
// Accepts byte-addressed load/store requests and sequences word-indexed
// reads, writes and read-modify-write for sub-word stores.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. The requester
// holds req_valid and the req_* fields stable until that edge. The answer
// is a single-cycle resp_valid pulse; resp_rdata/resp_err are only
// meaningful while resp_valid is high. There is no response back-pressure.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SEG_WORDS = SEG_WORDS_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [31:0]       mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [1:0]        dbg_state
);

   state_e            state_q,  state_d;
   logic              write_q,  write_d;
   size_e             size_q,   size_d;
   logic              signed_q, signed_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [31:0]       wdata_q,  wdata_d;
   logic [31:0]       old_q,    old_d;
   logic [31:0]       rdata_q,  rdata_d;
   logic              err_q,    err_d;

   size_e             req_size_e;
   logic [ADDR_W-1:0] req_index;
   logic [ADDR_W-1:0] cur_index;
   logic              req_bad;
   logic              in_write;
   logic [31:0]       load_data;
   logic [31:0]       merged;

   assign req_size_e = size_e'(req_size);
   assign req_index  = req_addr >> 2;
   assign cur_index  = addr_q >> 2;

   // Reject illegal size, misaligned half/word, and words past the segment end
   assign req_bad = (req_size_e == SZ_BAD)
                  | ((req_size_e == SZ_HALF) & req_addr[0])
                  | ((req_size_e == SZ_WORD) & (req_addr[1:0] != 2'b00))
                  | (req_index >= ADDR_W'(SEG_WORDS));

   mem_lane_unit u_lane (
      .rd_word_i   (mem_rd),
      .old_word_i  (old_q),
      .new_data_i  (wdata_q),
      .lane_i      (addr_q[1:0]),
      .size_i      (size_q),
      .signed_i    (signed_q),
      .load_data_o (load_data),
      .merged_o    (merged)
   );

   // Next-state, request latch and memory-port drive
   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      old_d    = old_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      in_write = 1'b0;
      mem_a    = 32'h0;
      mem_wd   = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               size_d   = req_size_e;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (!req_write || (req_size_e != SZ_WORD)) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_READ: begin
            mem_a = 32'(cur_index);
            old_d = mem_rd;
            if (!write_q) begin
               rdata_d = load_data;
               state_d = ST_RESP;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            in_write = 1'b1;
            mem_a    = 32'(cur_index);
            mem_wd   = (size_q == SZ_WORD) ? wdata_q : merged;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            rdata_d = 32'h0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and request registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         size_q   <= SZ_BYTE;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         old_q    <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         old_q    <= old_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // A reset landing in the WRITE cycle must suppress the write immediately
   assign mem_we     = in_write & ~reset;
   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, directed cases
// and randomized load/store traffic.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] tb_mem [32];
   logic        mem_clear;
   logic [7:0]  ref_bytes [128];
   logic [31:0] exp_q [$];

   mem_access_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd),
      .dbg_state  (dbg_state)
   );

   // clock / memory environment
   always #5 clk = ~clk;

   assign mem_rd = (mem_a < 32) ? tb_mem[mem_a[4:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 32; i++) tb_mem[i] <= 32'h0;
      end else if (mem_we && mem_a < 32) begin
         tb_mem[mem_a[4:0]] <= mem_wd;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: memory as a little-endian byte array
   task automatic ref_eval(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic e, output logic [31:0] rd, output logic [31:0] word,
                           output int lat, output int nwe);
      int nb;
      int base;
      int off;
      logic [31:0] v;
      e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a / 4 >= 32);
      rd = 32'h0; word = 32'h0; lat = 1; nwe = 0;
      if (e) return;
      nb = 1 << sz;
      if (!w) begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8 * i));
         if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         rd  = v;
         lat = 2;
      end else begin
         base = (int'(a) / 4) * 4;
         for (int j = 0; j < 4; j++) begin
            off = base + j - int'(a);
            if (off >= 0 && off < nb) word = word | (((wd >> (8 * off)) & 32'hFF) << (8 * j));
            else word = word | (32'(ref_bytes[base + j]) << (8 * j));
         end
         lat = (nb == 4) ? 2 : 3;
         nwe = 1;
      end
   endtask

   task automatic ref_commit(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int nb;
      nb = 1 << sz;
      for (int i = 0; i < nb; i++) ref_bytes[int'(a) + i] = 8'(wd >> (8 * i));
   endtask

   // driver + monitor for one request
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] got_rd, output logic [31:0] got_wd);
      logic        e;
      logic [31:0] erd, eword, qv;
      int          elat, enwe, lat, we_cnt;
      bit          done;
      ref_eval(w, sz, sg, a, wd, e, erd, eword, elat, enwe);
      exp_q.push_back(erd);
      got_rd = 32'h0; got_wd = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      check_eq("req_ready_wait", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; we_cnt = 0; done = 0;
      for (int c = 1; c <= 8 && !done; c++) begin
         @(negedge clk);
         check_eq("ready_busy", {31'h0, req_ready}, 32'h0);
         if (mem_we) begin
            we_cnt++;
            got_wd = mem_wd;
            check_eq("we_mem_a", mem_a, a >> 2);
            check_eq("we_mem_wd", mem_wd, eword);
         end
         if (resp_valid) begin
            done = 1;
            lat  = c;
            qv   = exp_q.pop_front();
            got_rd = resp_rdata;
            check_eq("resp_rdata", resp_rdata, qv);
            check_eq("resp_err", {31'h0, resp_err}, {31'h0, e});
            check_eq("resp_mem_a", mem_a, 32'h0);
         end
      end
      if (!done) begin
         check_eq("resp_timeout", 32'h0, 32'h1);
         void'(exp_q.pop_front());
      end
      check_eq("latency", lat, elat);
      check_eq("we_count", we_cnt, enwe);
      if (w && !e) ref_commit(sz, a, wd);
   endtask

   logic [31:0] rd, wdo, old_word;
   logic [31:0] r_addr;
   logic [1:0]  r_sz;

   initial begin
      for (int i = 0; i < 128; i++) ref_bytes[i] = 8'h0;
      reset = 1'b1; mem_clear = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;

      // reset for two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; mem_clear = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
      check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check_eq("rst_mem_a", mem_a, 32'h0);
      check_eq("rst_mem_wd", mem_wd, 32'h0);
      check_eq("rst_rdata", resp_rdata, 32'h0);
      check_eq("rst_err", {31'h0, resp_err}, 32'h0);

      // word store and load back
      do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, rd, wdo);
      check_eq("t2_store_wd", wdo, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, rd, wdo);
      check_eq("t2_load", rd, 32'hDEADBEEF);

      // sub-word loads with extension
      do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h123480FF, rd, wdo);
      do_req(1'b0, 2'd0, 1'b1, 32'h09, 32'h0, rd, wdo);
      check_eq("t3_byte_s", rd, 32'hFFFFFF80);
      do_req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, rd, wdo);
      check_eq("t3_byte_u", rd, 32'h00000080);
      do_req(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, rd, wdo);
      check_eq("t3_half_s", rd, 32'h00001234);

      // byte store read-modify-write
      do_req(1'b1, 2'd0, 1'b0, 32'h0B, 32'h000000AA, rd, wdo);
      check_eq("t4_merge", wdo, 32'hAA3480FF);

      // errors: misaligned and out of range
      do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, rd, wdo);
      check_eq("t5_misaligned_rd", rd, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, rd, wdo);
      check_eq("t5_range_rd", rd, 32'h0);
      do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h55, rd, wdo);

      // reset during the WRITE cycle aborts the store
      do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h0BADF00D, rd, wdo);
      old_word = tb_mem[5];
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h14; req_wdata = 32'h5555AAAA;
      for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("t6_we_before", {31'h0, mem_we}, 32'h1);
      reset = 1'b1;
      #1;
      check_eq("t6_we_gated", {31'h0, mem_we}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("t6_idle", {31'h0, req_ready}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("t6_no_resp", {31'h0, resp_valid}, 32'h0);
      end
      check_eq("t6_mem_kept", tb_mem[5], old_word);
      check_eq("t6_mem_kept_ref", tb_mem[5], 32'h0BADF00D);

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         r_sz = 2'($urandom_range(0, 3));
         r_addr = 32'($urandom_range(0, 35) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (r_sz == 2'd1) r_addr = r_addr & ~32'h1;
            if (r_sz == 2'd2) r_addr = r_addr & ~32'h3;
         end
         do_req(1'($urandom), r_sz, 1'($urandom), r_addr, $urandom, rd, wdo);
      end

      // final memory image against the byte-array model
      @(negedge clk);
      for (int i = 0; i < 32; i++)
         check_eq("final_mem", tb_mem[i],
                  {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});
      check_eq("exp_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
